// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - registered unsigned magnitude comparator slice with 7485-style cascade inputs
//
// Purpose:
//   Compares two unsigned WIDTH-bit operands and registers one-hot
//   eq/lt/gt flags one clock after the operands are sampled. When the
//   operands are equal, the result is taken from the cascade inputs of the
//   lower-significance slice. This lets slices chain into wider comparators.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   inA        in   WIDTH  operand A (unsigned)
//   inB        in   WIDTH  operand B (unsigned)
//   in_valid   in   1      sample inA/inB on this edge
//   casc_eq    in   1      cascade equal from lower slice (tie 1 when unused)
//   casc_lt    in   1      cascade less from lower slice (tie 0 when unused)
//   casc_gt    in   1      cascade greater from lower slice (tie 0 when unused)
//   A_eq_B     out  1      registered A == B
//   A_lt_B     out  1      registered A <  B
//   A_gt_B     out  1      registered A >  B
//   out_valid  out  1      registered: flags belong to a sampled pair

module comparator_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             in_valid,
    input  logic             casc_eq,
    input  logic             casc_lt,
    input  logic             casc_gt,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             A_gt_B,
    output logic             out_valid
);

    logic w_mag_gt;
    logic w_mag_lt;
    logic w_res_gt;
    logic w_res_lt;
    logic w_res_eq;

    // casc_eq carries no information of its own: with equal operands the
    // result is eq whenever neither casc_gt nor casc_lt is set. This covers
    // the all-zero cascade case as well. The pin exists for 7485 pin
    // compatibility only.
    logic w_unused_casc_eq;
    assign w_unused_casc_eq = casc_eq;

    logic r_eq;
    logic r_lt;
    logic r_gt;
    logic r_valid;

    assign w_mag_gt = (inA > inB);
    assign w_mag_lt = (inA < inB);

    // When the operands are equal, the cascade decides.
    // casc_gt has priority over casc_lt.
    always_comb begin
        w_res_gt = 1'b0;
        w_res_lt = 1'b0;
        w_res_eq = 1'b0;
        if (w_mag_gt) begin
            w_res_gt = 1'b1;
        end else if (w_mag_lt) begin
            w_res_lt = 1'b1;
        end else if (casc_gt) begin
            w_res_gt = 1'b1;
        end else if (casc_lt) begin
            w_res_lt = 1'b1;
        end else begin
            w_res_eq = 1'b1;
        end
    end

    // Flags hold across idle cycles. Only out_valid drops when no sample is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_eq <= w_res_eq;
                r_lt <= w_res_lt;
                r_gt <= w_res_gt;
            end
        end
    end

    assign A_eq_B    = r_eq;
    assign A_lt_B    = r_lt;
    assign A_gt_B    = r_gt;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// tb/tb_comparator_4bit.sv - directed self-checking bench for comparator_4bit

module tb_comparator_4bit;

    localparam logic [2:0] F_GT   = 3'b100;
    localparam logic [2:0] F_LT   = 3'b010;
    localparam logic [2:0] F_EQ   = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;

    logic       clk;
    logic       rst;
    logic [3:0] inA;
    logic [3:0] inB;
    logic       in_valid;
    logic       casc_eq;
    logic       casc_lt;
    logic       casc_gt;
    logic       A_eq_B;
    logic       A_lt_B;
    logic       A_gt_B;
    logic       out_valid;

    int n_checks;
    int n_fail;

    comparator_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .inA       (inA),
        .inB       (inB),
        .in_valid  (in_valid),
        .casc_eq   (casc_eq),
        .casc_lt   (casc_lt),
        .casc_gt   (casc_gt),
        .A_eq_B    (A_eq_B),
        .A_lt_B    (A_lt_B),
        .A_gt_B    (A_gt_B),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, then check 1 time unit after the edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic v, input logic ce, input logic cl, input logic cg,
                        input logic [2:0] exp_flags, input logic exp_valid,
                        input string tag);
        logic [2:0] obs;
        rst      = r;
        inA      = a;
        inB      = b;
        in_valid = v;
        casc_eq  = ce;
        casc_lt  = cl;
        casc_gt  = cg;
        @(posedge clk);
        #1;
        obs = {A_gt_B, A_lt_B, A_eq_B};
        n_checks++;
        assert (obs === exp_flags) else begin
            n_fail++;
            $error("FAIL %s flags{gt,lt,eq}: observed %b expected %b", tag, obs, exp_flags);
        end
        n_checks++;
        assert (out_valid === exp_valid) else begin
            n_fail++;
            $error("FAIL %s out_valid: observed %b expected %b", tag, out_valid, exp_valid);
        end
        if (exp_valid) begin
            n_checks++;
            assert ($onehot(obs)) else begin
                n_fail++;
                $error("FAIL %s onehot: observed %b expected one-hot", tag, obs);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; inA = 4'd0; inB = 4'd0; in_valid = 1'b0;
        casc_eq = 1'b1; casc_lt = 1'b0; casc_gt = 1'b0;
        @(negedge clk);

        // Reset dominates in_valid
        step(1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, F_NONE, 1'b0, "reset_c1");
        step(1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, F_NONE, 1'b0, "reset_c2");
        step(1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, F_GT,   1'b1, "first_after_reset");

        // Sweep A=7 against B=0..15
        for (int b = 0; b < 16; b++) begin
            step(1'b0, 4'd7, 4'(b), 1'b1, 1'b1, 1'b0, 1'b0,
                 (b < 7) ? F_GT : ((b == 7) ? F_EQ : F_LT), 1'b1,
                 $sformatf("sweep_b%0d", b));
        end

        // Extremes
        step(1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, F_EQ, 1'b1, "ext_0_0");
        step(1'b0, 4'd0,  4'd15, 1'b1, 1'b1, 1'b0, 1'b0, F_LT, 1'b1, "ext_0_15");
        step(1'b0, 4'd15, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, F_GT, 1'b1, "ext_15_0");
        step(1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, F_EQ, 1'b1, "ext_15_15");

        // Cascade resolution with equal operands
        step(1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, F_GT, 1'b1, "casc_gt");
        step(1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, F_LT, 1'b1, "casc_lt");
        step(1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, F_EQ, 1'b1, "casc_zero");
        step(1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, F_GT, 1'b1, "casc_gt_lt");
        step(1'b0, 4'hA, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, F_EQ, 1'b1, "casc_eq");
        step(1'b0, 4'd3, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, F_LT, 1'b1, "casc_ignored");

        // Hold on in_valid=0
        step(1'b0, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, F_GT, 1'b1, "hold_sample");
        step(1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, F_GT, 1'b0, "hold_idle1");
        step(1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, F_GT, 1'b0, "hold_idle2");

        // Reset mid-stream discards the in-flight result
        step(1'b0, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, F_GT,   1'b1, "mid_sample");
        step(1'b1, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, F_NONE, 1'b0, "mid_reset");
        step(1'b0, 4'd1, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, F_NONE, 1'b0, "post_reset_idle");
        step(1'b0, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, F_LT,   1'b1, "post_reset_valid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
